key_matrix_scanner: RTL and testbench

- Input-side counterpart of the LED matrix row scanner: drives one keypad row low at a time and reads the column lines back.
- Targets a 4x4 active-low keypad with pull-ups on the columns.
- Debounces the full key bitmap frame by frame and reports single-key presses to downstream logic through a valid/ack handshake.
- Runs in the same slow scan clock domain as the display (1 kHz recommended).

---
 rtl/key_matrix_scanner.sv | 134 +++++++++++++
 tb/tb_key_matrix_scanner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_matrix_scanner.sv
// 4x4 active-low keypad scanner: row strobe, frame-level debounce and single-key
// press events over a valid/ack handshake. Define KEY_REPEAT_EN for auto-repeat.
module key_matrix_scanner #(
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int REPEAT_FRAMES   = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_i,
  input  logic        key_ack,
  output logic [3:0]  row_o,
  output logic [15:0] key_map,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        overrun
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE_FRAMES);

  logic [1:0]  row_idx;
  logic [15:0] snapshot;
  logic [15:0] prev_frame;
  logic [15:0] cur;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic        frame_end;
  logic        map_load;
  logic        press_event;
  logic        event_fire;
  logic [3:0]  event_code;

  function automatic logic is_onehot(input logic [15:0] m);
    return (m != 16'd0) && ((m & (m - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] encode(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    row_o = ~(4'b0001 << row_idx);
  end

  // Row 3 is being sampled on the frame-end edge, so splice it in directly.
  always_comb begin
    cur        = snapshot;
    cur[15:12] = ~col_i;
    frame_end  = (row_idx == 2'd3);
    if (cur == prev_frame) begin
      cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end else begin
      cnt_next = 8'd1;
    end
    map_load    = frame_end && (cnt_next == DEB) && (cur != key_map);
    press_event = map_load && is_onehot(cur) && (key_map == 16'd0);
  end

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] REP = 8'(REPEAT_FRAMES);

  logic [7:0] rep_cnt;
  logic       rep_arm;
  logic       rep_fire;

  always_comb begin
    rep_fire   = frame_end && !map_load && rep_arm && ((rep_cnt + 8'd1) == REP);
    event_fire = press_event || rep_fire;
    event_code = rep_fire ? encode(key_map) : encode(cur);
  end

  // Armed only by a genuine press, so single-to-single slides never repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= 8'd0;
      rep_arm <= 1'b0;
    end else if (map_load) begin
      rep_cnt <= 8'd0;
      rep_arm <= press_event;
    end else if (frame_end && rep_arm) begin
      rep_cnt <= rep_fire ? 8'd0 : rep_cnt + 8'd1;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^8'(REPEAT_FRAMES);

  always_comb begin
    event_fire = press_event;
    event_code = encode(cur);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx    <= 2'd0;
      snapshot   <= 16'd0;
      prev_frame <= 16'd0;
      cnt        <= 8'd0;
      key_map    <= 16'd0;
    end else begin
      row_idx                  <= row_idx + 2'd1;
      snapshot[row_idx*4 +: 4] <= ~col_i;
      if (frame_end) begin
        prev_frame <= cur;
        cnt        <= cnt_next;
        if (map_load) key_map <= cur;
      end
    end
  end

  // A same-edge ack frees the slot, so the new event loads instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overrun   <= 1'b0;
    end else if (event_fire) begin
      if (!key_valid || key_ack) begin
        key_valid <= 1'b1;
        key_code  <= event_code;
      end else begin
        overrun <= 1'b1;
      end
    end else if (key_valid && key_ack) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a behavioural keypad and a queue of
// expected key codes; repeat expectations follow KEY_REPEAT_EN.
module tb_key_matrix_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_i;
  logic        key_ack;
  logic [3:0]  row_o;
  logic [15:0] key_map;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        overrun;

  logic [15:0] keys;
  int          edge_cnt;
  int          n_checks;
  int          n_fail;
  logic [3:0]  sb[$];

  key_matrix_scanner #(.DEBOUNCE_FRAMES(3), .REPEAT_FRAMES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_i     (col_i),
    .key_ack   (key_ack),
    .row_o     (row_o),
    .key_map   (key_map),
    .key_code  (key_code),
    .key_valid (key_valid),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key shorts its row to its column; columns idle high.
  always_comb begin
    col_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_o[r]) col_i = col_i & ~keys[r*4 +: 4];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    while (edge_cnt % 4 != 0) @(negedge clk);
  endtask

  task automatic expect_event(input string tag, input int start, input int lat, output int ev_edge);
    int n;
    logic [3:0] exp_code;
    n = 0;
    while (key_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ev_edge = edge_cnt;
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
    if (key_valid === 1'b1) begin
      exp_code = (sb.size() > 0) ? sb.pop_front() : 4'hx;
      check({tag, "_code"}, 32'(key_code), 32'(exp_code));
      check({tag, "_latency"}, 32'(edge_cnt - start), 32'(lat));
    end
    $display("event %s: code=%0d edge=%0d", tag, key_code, edge_cnt);
  endtask

  task automatic do_ack(input string tag);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check({tag, "_ack"}, 32'(key_valid), 32'd0);
  endtask

  task automatic release_all();
    keys = 16'd0;
    align();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"},     32'(row_o),     32'hE);
    check({tag, "_map"},     32'(key_map),   32'h0);
    check({tag, "_code"},    32'(key_code),  32'h0);
    check({tag, "_valid"},   32'(key_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun),   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int ev;
    logic [3:0] exp_row;
    n_checks = 0;
    n_fail   = 0;
    keys     = 16'd0;
    key_ack  = 1'b0;
    rst_n    = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_row = ~(4'b0001 << (i % 4));
      check($sformatf("row_step%0d", i), 32'(row_o), 32'(exp_row));
      @(negedge clk);
    end

    // Single press of key 6 (row 1, col 2) from a frame boundary.
    align();
    s = edge_cnt;
    keys = 16'h0040;
    sb.push_back(4'd6);
    expect_event("single", s, 12, ev);
    check("single_map", 32'(key_map), 32'h0040);
    do_ack("single");
    release_all();
    check("single_release_map", 32'(key_map), 32'h0);

    // Bounce on row 1 during frame 2 restarts the debounce.
    align();
    s = edge_cnt;
    keys = 16'h0040;
    repeat (5) @(negedge clk);
    keys = 16'h0000;
    @(negedge clk);
    keys = 16'h0040;
    sb.push_back(4'd6);
    expect_event("bounce", s, 20, ev);
    do_ack("bounce");
    repeat (16) @(negedge clk);
    check("bounce_single_event", 32'(key_valid), 32'd0);
    release_all();

    // Overrun: key 0 pending, key 15 dropped.
    align();
    s = edge_cnt;
    keys = 16'h0001;
    sb.push_back(4'd0);
    expect_event("ovr_first", s, 12, ev);
    release_all();
    align();
    keys = 16'h8000;
    repeat (12) @(negedge clk);
    check("ovr_map",     32'(key_map),   32'h8000);
    check("ovr_code",    32'(key_code),  32'h0);
    check("ovr_valid",   32'(key_valid), 32'h1);
    check("ovr_overrun", 32'(overrun),   32'h1);

    // Asynchronous reset mid-scan drops everything.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    keys = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Same sequence with ack on the key-15 update edge.
    align();
    s = edge_cnt;
    keys = 16'h0001;
    sb.push_back(4'd0);
    expect_event("ackovr_first", s, 12, ev);
    release_all();
    align();
    keys = 16'h8000;
    sb.push_back(4'd15);
    repeat (11) @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("ackovr_valid",   32'(key_valid), 32'h1);
    check("ackovr_code",    32'(key_code),  32'(sb.size() > 0 ? sb.pop_front() : 4'hx));
    check("ackovr_overrun", 32'(overrun),   32'h0);
    $display("event ackovr: code=%0d edge=%0d", key_code, edge_cnt);
    do_ack("ackovr");
    release_all();

    // Multi-key gives no event; a clean single press afterwards does.
    align();
    keys = 16'h0021;
    repeat (12) @(negedge clk);
    check("multi_map",   32'(key_map),   32'h0021);
    check("multi_valid", 32'(key_valid), 32'h0);
    keys = 16'h0000;
    repeat (12) @(negedge clk);
    check("multi_release_map", 32'(key_map), 32'h0);
    s = edge_cnt;
    keys = 16'h0020;
    sb.push_back(4'd5);
    expect_event("multi_single", s, 12, ev);
    do_ack("multi_single");
    release_all();

    // Hold key 3 and ack each event.
    align();
    s = edge_cnt;
    keys = 16'h0008;
    sb.push_back(4'd3);
    expect_event("hold", s, 12, ev);
    do_ack("hold");
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 2; k++) begin
      s = ev;
      sb.push_back(4'd3);
      expect_event($sformatf("repeat%0d", k), s, 8, ev);
      do_ack($sformatf("repeat%0d", k));
    end
`else
    repeat (20) @(negedge clk);
    check("hold_no_repeat", 32'(key_valid), 32'h0);
`endif
    check("hold_map", 32'(key_map), 32'h0008);
    release_all();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
